// File: rtl/ycc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ycc_pkg
// Description : Shared types, blanking constants and the rounding average
//               used by the 4:4:4 -> 4:2:2 packer.
// Revision    : 1.0 - initial release
// ============================================================================
package ycc_pkg;

    localparam logic [7:0] BLANK_Y  = 8'h10;
    localparam logic [7:0] BLANK_C  = 8'h80;
    localparam int         PIPE_LAT = 3;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycc444_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vctl_t;

    localparam ycc444_t     BLANK_444 = '{y: BLANK_Y, cb: BLANK_C, cr: BLANK_C};
    localparam logic [15:0] BLANK_422 = {BLANK_C, BLANK_Y};

    // 9-bit sum keeps the carry, so the half-up result always fits 8 bits
    function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return w_sum[8:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ycc422_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : ycc422_packer_if
// Description : Video bus into and out of the packer: 24-bit 4:4:4 in,
//               16-bit 4:2:2 out, each with DE/HS/VS.
// Revision    : 1.0 - initial release
// ============================================================================
interface ycc422_packer_if;

    logic        in_de;
    logic        in_hs;
    logic        in_vs;
    logic [23:0] in_data;

    logic        out_de;
    logic        out_hs;
    logic        out_vs;
    logic [15:0] out_data;

    modport master (
        output in_de, in_hs, in_vs, in_data,
        input  out_de, out_hs, out_vs, out_data
    );

    modport slave (
        input  in_de, in_hs, in_vs, in_data,
        output out_de, out_hs, out_vs, out_data
    );

endinterface
`default_nettype wire

// File: rtl/video_meas.sv
`default_nettype none
// ============================================================================
// Module      : video_meas
// Description : Raster measurement: active width, active line count and
//               frame count, derived from DE and VS edges.
// Revision    : 1.0 - initial release
// ============================================================================
module video_meas #(
    parameter int MEAS_W = 12
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_de,
    input  wire logic              i_vs,
    output logic [MEAS_W-1:0]      o_width,
    output logic [MEAS_W-1:0]      o_height,
    output logic [15:0]            o_frames
);

    localparam logic [MEAS_W-1:0] c_MAX = '1;
    localparam logic [MEAS_W-1:0] c_ONE = MEAS_W'(1);

    logic              r_de;
    logic              r_vs;
    logic              r_armed;
    logic [MEAS_W-1:0] r_pix_cnt;
    logic [MEAS_W-1:0] r_line_cnt;
    logic [MEAS_W-1:0] r_width;
    logic [MEAS_W-1:0] r_height;
    logic [15:0]       r_frames;

    logic              w_de_fall;
    logic              w_vs_rise;
    logic              w_line_done;
    logic [MEAS_W-1:0] w_line_inc;

    assign w_de_fall  = r_de & ~i_de;
    assign w_vs_rise  = i_vs & ~r_vs;
    assign w_line_inc = (r_line_cnt == c_MAX) ? r_line_cnt : r_line_cnt + c_ONE;

    // A line already in progress when reset releases has no true start,
    // so it is only measured once DE has been seen low.
    assign w_line_done = w_de_fall & r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_de       <= 1'b0;
            r_vs       <= 1'b0;
            r_armed    <= 1'b0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_frames   <= '0;
        end else begin
            r_de <= i_de;
            r_vs <= i_vs;
            if (!i_de) begin
                r_armed <= 1'b1;
            end

            if (w_de_fall) begin
                r_pix_cnt <= '0;
            end else if (i_de && (r_pix_cnt != c_MAX)) begin
                r_pix_cnt <= r_pix_cnt + c_ONE;
            end

            if (w_line_done) begin
                r_width <= r_pix_cnt;
            end

            if (w_vs_rise) begin
                r_height   <= w_line_done ? w_line_inc : r_line_cnt;
                r_line_cnt <= '0;
                r_frames   <= r_frames + 16'd1;
            end else if (w_line_done) begin
                r_line_cnt <= w_line_inc;
            end
        end
    end

    assign o_width  = r_width;
    assign o_height = r_height;
    assign o_frames = r_frames;

endmodule
`default_nettype wire

// File: rtl/ycc422_packer.sv
`default_nettype none
// ============================================================================
// Module      : ycc422_packer
// Description : 4:4:4 -> 4:2:2 YCbCr packer with chroma averaging, blanking,
//               fixed 3-cycle latency and raster measurement.
// Revision    : 1.0 - initial release
// ============================================================================
module ycc422_packer
    import ycc_pkg::*;
#(
    parameter bit AVG_EN_DEFAULT = 1'b1,
    parameter int MEAS_W         = 12
) (
    input  wire logic              sys2_clk,
    input  wire logic              sys2_rst,
    input  wire logic              cfg_avg,
    ycc422_packer_if.slave         bus,
    output logic [MEAS_W-1:0]      meas_width,
    output logic [MEAS_W-1:0]      meas_height,
    output logic [15:0]            meas_frames
);

    // r_ctl[0] = input register, [1] = pair window, [PIPE_LAT-1] = output
    vctl_t [PIPE_LAT-1:0] r_ctl;
    vctl_t                w_in_ctl;

    ycc444_t     r1_pix;
    ycc444_t     r2_pix;
    logic        r1_odd;
    logic        r2_odd;
    logic        r1_avg;
    logic        r2_avg;
    logic [7:0]  r_c_odd;
    logic [15:0] r_out_data;

    logic        w_s2_even;
    logic        w_pair;
    logic [7:0]  w_c;
    logic [7:0]  w_c_odd_next;

    assign w_in_ctl = '{de: bus.in_de, hs: bus.in_hs, vs: bus.in_vs};

    always_ff @(posedge sys2_clk) begin
        if (sys2_rst) begin
            r_ctl      <= '0;
            r1_pix     <= BLANK_444;
            r2_pix     <= BLANK_444;
            r1_odd     <= 1'b0;
            r2_odd     <= 1'b0;
            r1_avg     <= AVG_EN_DEFAULT;
            r2_avg     <= AVG_EN_DEFAULT;
            r_c_odd    <= BLANK_C;
            r_out_data <= BLANK_422;
        end else begin
            r_ctl  <= {r_ctl[PIPE_LAT-2:0], w_in_ctl};
            r1_pix <= bus.in_data;
            // r_ctl[0].de is the previous DE, so a rising edge restarts on even
            r1_odd <= (bus.in_de && r_ctl[0].de) ? ~r1_odd : 1'b0;
            r1_avg <= cfg_avg;

            r2_pix  <= r1_pix;
            r2_odd  <= r1_odd;
            r2_avg  <= r1_avg;
            r_c_odd <= w_c_odd_next;

            r_out_data <= r_ctl[1].de ? {w_c, r2_pix.y} : BLANK_422;
        end
    end

    // With E in the pair window and O one stage behind, both chroma results
    // are formed together; O's is held one cycle until O reaches the window.
    assign w_s2_even = r_ctl[1].de & ~r2_odd;
    assign w_pair    = w_s2_even & r_ctl[0].de & r1_odd;

    always_comb begin
        w_c          = r_c_odd;
        w_c_odd_next = r_c_odd;
        if (w_s2_even) begin
            if (w_pair && r2_avg) begin
                w_c = avg_round(r2_pix.cb, r1_pix.cb);
            end else begin
                w_c = r2_pix.cb;
            end
        end
        if (w_pair) begin
            w_c_odd_next = r2_avg ? avg_round(r2_pix.cr, r1_pix.cr) : r1_pix.cr;
        end
    end

    assign bus.out_de   = r_ctl[PIPE_LAT-1].de;
    assign bus.out_hs   = r_ctl[PIPE_LAT-1].hs;
    assign bus.out_vs   = r_ctl[PIPE_LAT-1].vs;
    assign bus.out_data = r_out_data;

    video_meas #(
        .MEAS_W (MEAS_W)
    ) u_meas (
        .clk      (sys2_clk),
        .rst      (sys2_rst),
        .i_de     (bus.in_de),
        .i_vs     (bus.in_vs),
        .o_width  (meas_width),
        .o_height (meas_height),
        .o_frames (meas_frames)
    );

endmodule
`default_nettype wire

// File: tb/tb_ycc422_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ycc422_packer
// Description : Scoreboard bench for ycc422_packer with a line-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ycc422_packer;
    import ycc_pkg::*;

    localparam int c_LMAX = 4200;

    logic        sys2_clk = 1'b0;
    logic        sys2_rst = 1'b1;
    logic        cfg_avg  = 1'b1;
    logic [11:0] meas_width;
    logic [11:0] meas_height;
    logic [15:0] meas_frames;

    ycc422_packer_if bus ();

    ycc422_packer #(
        .AVG_EN_DEFAULT (1'b1),
        .MEAS_W         (12)
    ) dut (
        .sys2_clk    (sys2_clk),
        .sys2_rst    (sys2_rst),
        .cfg_avg     (cfg_avg),
        .bus         (bus),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .meas_frames (meas_frames)
    );

    always #5 sys2_clk = ~sys2_clk;

    int          checks = 0;
    int          errors = 0;
    vctl_t       ctl_q[$];
    logic [15:0] pix_q[$];
    bit          mon_en = 1'b0;

    logic [7:0]  ly  [c_LMAX];
    logic [7:0]  lcb [c_LMAX];
    logic [7:0]  lcr [c_LMAX];
    logic        lavg[c_LMAX];
    logic [15:0] lexp[c_LMAX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Output model: a 3-deep control delay that reset empties
    always @(posedge sys2_clk) begin
        if (sys2_rst) begin
            ctl_q.delete();
            repeat (PIPE_LAT) ctl_q.push_back(vctl_t'(3'b000));
            pix_q.delete();
            mon_en = 1'b1;
        end else if (mon_en) begin
            void'(ctl_q.pop_front());
            ctl_q.push_back('{de: bus.in_de, hs: bus.in_hs, vs: bus.in_vs});
        end
    end

    always @(negedge sys2_clk) begin
        vctl_t e;
        if (mon_en) begin
            e = ctl_q[0];
            check("ctl", {bus.out_de, bus.out_hs, bus.out_vs}, e);
            if (e.de) begin
                if (pix_q.size() == 0) begin
                    check("pix_q_empty", 1, 0);
                end else begin
                    check("pix", bus.out_data, pix_q.pop_front());
                end
            end else begin
                check("blank", bus.out_data, 16'h8010);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys2_clk);
        #1;
    endtask

    function automatic logic [7:0] rnd8();
        case ($urandom_range(0, 3))
            0:       return 8'd0;
            1:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            ly[i]   = rnd8();
            lcb[i]  = rnd8();
            lcr[i]  = rnd8();
            lavg[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Expected 4:2:2 words for pixels s..e-1, s being the first (even) pixel
    task automatic model_line(input int s, input int e);
        int ce, co;
        for (int k = s; k < e; k += 2) begin
            if (k + 1 < e) begin
                if (lavg[k]) begin
                    ce = (int'(lcb[k]) + int'(lcb[k+1]) + 1) / 2;
                    co = (int'(lcr[k]) + int'(lcr[k+1]) + 1) / 2;
                end else begin
                    ce = int'(lcb[k]);
                    co = int'(lcr[k+1]);
                end
                lexp[k]   = {ce[7:0], ly[k]};
                lexp[k+1] = {co[7:0], ly[k+1]};
            end else begin
                lexp[k] = {lcb[k], ly[k]};
            end
        end
    endtask

    task automatic set_px(input int i, input bit push);
        bus.in_de   = 1'b1;
        bus.in_hs   = 1'b0;
        bus.in_vs   = 1'b0;
        bus.in_data = {ly[i], lcb[i], lcr[i]};
        cfg_avg     = lavg[i];
        if (push) pix_q.push_back(lexp[i]);
    endtask

    task automatic set_blank(input bit hs, input bit vs);
        bus.in_de   = 1'b0;
        bus.in_hs   = hs;
        bus.in_vs   = vs;
        bus.in_data = 24'($urandom());
        cfg_avg     = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_line(input int n);
        for (int i = 0; i < n; i++) begin
            set_px(i, 1'b1);
            tick();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_blank(1'($urandom_range(0, 1)), 1'b0);
            tick();
        end
    endtask

    task automatic load4(input logic [31:0] y, input logic [31:0] cb, input logic [31:0] cr,
                         input logic [63:0] ex, input bit avg);
        for (int i = 0; i < 4; i++) begin
            ly[i]   = y[31-8*i -: 8];
            lcb[i]  = cb[31-8*i -: 8];
            lcr[i]  = cr[31-8*i -: 8];
            lavg[i] = avg;
            lexp[i] = ex[63-16*i -: 16];
        end
    endtask

    task automatic frame(input bit chk);
        for (int l = 0; l < 24; l++) begin
            if (l >= 4) begin
                fill_rand(64);
                model_line(0, 64);
            end
            for (int x = 0; x < 80; x++) begin
                if (l >= 4 && x < 64) set_px(x, 1'b1);
                else set_blank(x >= 68 && x < 74, l < 2);
                tick();
            end
            if (chk && l == 0) begin
                check("raster_height", meas_height, 12'd20);
                check("raster_frames", meas_frames, 16'd2);
                check("raster_width", meas_width, 12'd64);
            end
        end
    endtask

    task automatic hd_line(input int rst_at);
        fill_rand(1920);
        model_line(0, 1920);
        for (int x = 0; x < 2200; x++) begin
            if (x < 1920) begin
                set_px(x, x != rst_at);
                if (x == rst_at) sys2_rst = 1'b1;
            end else begin
                set_blank(x >= 2008 && x < 2052, 1'b0);
            end
            tick();
            if (x == rst_at) begin
                check("midrst_width", meas_width, 12'd0);
                check("midrst_height", meas_height, 12'd0);
                check("midrst_frames", meas_frames, 16'd0);
                check("midrst_out_data", bus.out_data, 16'h8010);
                sys2_rst = 1'b0;
                model_line(rst_at + 1, 1920);
            end
        end
    endtask

    initial begin
        int n;
        logic [11:0] w_hold;
        set_blank(1'b0, 1'b0);
        sys2_rst = 1'b1;
        tick();
        tick();
        check("rst_out_de", bus.out_de, 1'b0);
        check("rst_out_data", bus.out_data, 16'h8010);
        check("rst_width", meas_width, 12'd0);
        check("rst_height", meas_height, 12'd0);
        check("rst_frames", meas_frames, 16'd0);
        sys2_rst = 1'b0;
        idle(4);

        // Directed pair lines: averaged, then decimated
        load4({8'd10, 8'd20, 8'd30, 8'd40}, {8'd100, 8'd101, 8'd200, 8'd202},
              {8'd50, 8'd53, 8'd0, 8'd1},
              {8'd101, 8'd10, 8'd52, 8'd20, 8'd201, 8'd30, 8'd1, 8'd40}, 1'b1);
        drive_line(4);
        idle(4);
        check("width_4_avg", meas_width, 12'd4);
        load4({8'd10, 8'd20, 8'd30, 8'd40}, {8'd100, 8'd101, 8'd200, 8'd202},
              {8'd50, 8'd53, 8'd0, 8'd1},
              {8'd100, 8'd10, 8'd53, 8'd20, 8'd200, 8'd30, 8'd1, 8'd40}, 1'b0);
        drive_line(4);
        idle(4);

        // Odd line with an orphan, then a 2-pixel line that must start even
        load4({8'd1, 8'd2, 8'd3, 8'd0}, {8'd5, 8'd6, 8'd77, 8'd0}, {8'd7, 8'd8, 8'd9, 8'd0},
              {8'd6, 8'd1, 8'd8, 8'd2, 8'd77, 8'd3, 8'd0, 8'd0}, 1'b1);
        drive_line(3);
        idle(3);
        check("width_3_odd", meas_width, 12'd3);
        load4({8'd4, 8'd5, 8'd0, 8'd0}, {8'd10, 8'd20, 8'd0, 8'd0}, {8'd30, 8'd41, 8'd0, 8'd0},
              {8'd15, 8'd4, 8'd36, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b1);
        drive_line(2);
        idle(3);
        check("width_2_even", meas_width, 12'd2);

        // Random lines: random lengths, data and per-pixel cfg_avg
        for (int r = 0; r < 24; r++) begin
            n = $urandom_range(1, 40);
            fill_rand(n);
            model_line(0, n);
            drive_line(n);
            idle($urandom_range(2, 6));
            check("width_rand", meas_width, 12'(n));
        end

        // Small raster after a fresh reset: 64x20 active in 80x24
        set_blank(1'b0, 1'b0);
        sys2_rst = 1'b1;
        tick();
        sys2_rst = 1'b0;
        idle(3);
        frame(1'b0);
        frame(1'b1);
        idle(4);

        // 1920-wide lines with a reset at pixel 500 of the second
        hd_line(-1);
        check("hd_width", meas_width, 12'd1920);
        hd_line(500);
        check("hd_partial_width", meas_width, 12'd0);
        hd_line(-1);
        check("hd_width_after_rst", meas_width, 12'd1920);

        // Pixel counter saturation
        fill_rand(4100);
        model_line(0, 4100);
        drive_line(4100);
        idle(4);
        check("width_saturate", meas_width, 12'hFFF);

        // Controls only: sync toggling with DE low
        w_hold = meas_width;
        for (int i = 0; i < 300; i++) begin
            set_blank(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end
        check("ctl_only_width", meas_width, w_hold);

        idle(6);
        check("pix_q_drained", pix_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
